// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg
//   Shared types and constants for the per-frame update sequencer.
//   fs_state_t      : sequencer FSM states
//   SKIP_CNT_WIDTH  : width of the saturating skipped-trigger counter
package frame_scheduler_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_START,
        FS_WAIT
    } fs_state_t;

    localparam int SKIP_CNT_WIDTH = 8;
    localparam logic [SKIP_CNT_WIDTH-1:0] SKIP_CNT_MAX = '1;

endpackage

// File: rtl/frame_scheduler_edge_detector.sv
// edge_detector
//   Rising-edge detector built on a registered copy of the input.
//   The delayed copy is registered. The pulse is sig & ~sig_q, so it is high
//   in the same cycle that sig first reads high. The scheduler registers
//   every action it takes on this pulse, which keeps the block's outputs
//   one cycle behind the edge.
//   Ports:
//     clk  in  clock
//     rst  in  asynchronous active-high reset (clears the history to 0)
//     sig  in  level to watch
//     rise out one-cycle pulse on a 0->1 transition of sig
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Clearing to 0 on reset means a level already high at release
    // shows up as an edge on the first clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Runs a fixed chain of per-frame game update stages on every vsync
//   rising edge. It uses a start/done handshake with one stage at a time.
//   It flags stages that stall (timeout) and sequences still running when
//   active video resumes (overrun).
//   Ports:
//     clk_rgb        in   pixel clock
//     rst            in   asynchronous active-high reset
//     enable         in   0 drops new triggers; a running sequence completes
//     vs, de         in   timing from pixel_iterator
//     stage_done     in   per-stage completion pulse (only current idx used)
//     clear_flags    in   clears overrun/timeout (a same-cycle set wins)
//     stage_start    out  one-hot start pulse for the current stage
//     stage_idx      out  current/last stage index
//     busy           out  sequence in progress
//     overrun        out  sticky: de rose while busy
//     timeout        out  sticky: a stage was force-advanced
//     frame_count    out  completed sequences (wraps)
//     skipped_frames out  triggers ignored while busy (saturates)
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int N_STAGES        = 3,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int IDX_W          = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                       clk_rgb,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       vs,
    input  logic                       de,
    input  logic [N_STAGES-1:0]        stage_done,
    input  logic                       clear_flags,
    output logic [N_STAGES-1:0]        stage_start,
    output logic [IDX_W-1:0]           stage_idx,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic [SKIP_CNT_WIDTH-1:0]  skipped_frames
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    fs_state_t        state;
    logic [CNT_W-1:0] wait_cnt;

    logic vs_rise, de_rise;
    logic trig, in_seq;
    logic done_cur, cnt_hit, advance, last_stage;
    logic [IDX_W-1:0] next_idx;

    edge_detector u_vs_edge (
        .clk  (clk_rgb),
        .rst  (rst),
        .sig  (vs),
        .rise (vs_rise)
    );

    edge_detector u_de_edge (
        .clk  (clk_rgb),
        .rst  (rst),
        .sig  (de),
        .rise (de_rise)
    );

    assign trig       = vs_rise & enable;
    // Covers the final WAIT cycle as well, so a trigger that lands while
    // the FSM is returning to IDLE is counted as skipped, not started.
    assign in_seq     = (state != FS_IDLE);
    assign done_cur   = stage_done[stage_idx];
    assign cnt_hit    = (wait_cnt == CNT_LAST);
    assign advance    = (state == FS_WAIT) && (done_cur || cnt_hit);
    assign last_stage = (stage_idx == LAST_IDX);
    assign next_idx   = stage_idx + IDX_W'(1);

    // Sequencer. stage_done is only looked at in WAIT, so a done pulse
    // that coincides with its own start is lost by design.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            state       <= FS_IDLE;
            stage_start <= '0;
            stage_idx   <= '0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            frame_count <= '0;
        end else begin
            stage_start <= '0;
            case (state)
                FS_IDLE: begin
                    if (trig) begin
                        state       <= FS_START;
                        stage_idx   <= '0;
                        stage_start <= N_STAGES'(1);
                        busy        <= 1'b1;
                    end
                end
                FS_START: begin
                    wait_cnt <= '0;
                    state    <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (advance) begin
                        if (last_stage) begin
                            state       <= FS_IDLE;
                            busy        <= 1'b0;
                            frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
                        end else begin
                            state       <= FS_START;
                            stage_idx   <= next_idx;
                            stage_start <= N_STAGES'(1) << next_idx;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= FS_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags. A set event in the same cycle as clear_flags wins.
    // A done that arrives on the last allowed cycle counts as on time.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (de_rise && in_seq)  overrun <= 1'b1;
            else if (clear_flags)   overrun <= 1'b0;

            if (advance && cnt_hit && !done_cur) timeout <= 1'b1;
            else if (clear_flags)                timeout <= 1'b0;
        end
    end

    // Triggers that arrive mid-sequence are counted, never queued.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            skipped_frames <= '0;
        end else if (trig && in_seq && (skipped_frames != SKIP_CNT_MAX)) begin
            skipped_frames <= skipped_frames + SKIP_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (N_STAGES=3, TIMEOUT_CYCLES=8).
// Cycle k is the time #1 after clock edge k. Inputs set there are sampled
// at edge k+1. Registered outputs seen there reflect edge k.
module tb_frame_scheduler;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int FW = 16;

    logic          clk_rgb = 1'b0;
    logic          rst, enable, vs, de, clear_flags;
    logic [N-1:0]  stage_done, stage_start;
    logic [1:0]    stage_idx;
    logic          busy, overrun, timeout;
    logic [FW-1:0] frame_count;
    logic [7:0]    skipped_frames;

    int errors = 0;
    int checks = 0;
    int exp_fc = 0;
    int exp_skip = 0;

    frame_scheduler #(
        .N_STAGES(N), .TIMEOUT_CYCLES(TO), .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk_rgb(clk_rgb), .rst(rst), .enable(enable), .vs(vs), .de(de),
        .stage_done(stage_done), .clear_flags(clear_flags),
        .stage_start(stage_start), .stage_idx(stage_idx), .busy(busy),
        .overrun(overrun), .timeout(timeout), .frame_count(frame_count),
        .skipped_frames(skipped_frames)
    );

    always #5 clk_rgb = ~clk_rgb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_rgb);
        #1;
    endtask

    // Answer the current stage and every later one, one cycle after each
    // START. The task is entered in WAIT of 'first' and returns in IDLE.
    task automatic finish_from_wait(input int first);
        for (int i = first; i < N; i++) begin
            stage_done = N'(1) << i;
            step();
            stage_done = '0;
            if (i < N - 1) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; vs = 1'b0; de = 1'b0;
        stage_done = '0; clear_flags = 1'b0;
        step(); step();
        checks++;
        if ({stage_start, stage_idx, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got start=%b idx=%0d busy=%b, expected all 0",
                     stage_start, stage_idx, busy);
        end
        checks++;
        if ({overrun, timeout, frame_count, skipped_frames} !== '0) begin
            errors++;
            $display("FAIL reset_stat got ovr=%b to=%b fc=%0d skip=%0d, expected all 0",
                     overrun, timeout, frame_count, skipped_frames);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_enable_low();
        enable = 1'b0; vs = 1'b1;
        step();
        vs = 1'b0;
        checks++;
        if ({stage_start, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL enable_low_start got start=%b busy=%b, expected 000/0",
                     stage_start, busy);
        end
        step();
        checks++;
        if (skipped_frames !== 8'd0) begin
            errors++;
            $display("FAIL enable_low_skip got %0d expected 0", skipped_frames);
        end
        enable = 1'b1;
        step();
    endtask

    // Each stage answers 5 cycles after its start. The vs edge at k=18
    // arrives while the FSM is returning to IDLE, so it must be skipped.
    task automatic test_sequence();
        logic [N-1:0] exp_start;
        logic [1:0]   exp_idx;
        vs = 1'b1;
        step();
        vs = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            exp_start = (k == 1) ? 3'b001 : (k == 7) ? 3'b010 :
                        (k == 13) ? 3'b100 : 3'b000;
            exp_idx   = (k < 7) ? 2'd0 : (k < 13) ? 2'd1 : 2'd2;
            checks++;
            if (stage_start !== exp_start) begin
                errors++;
                $display("FAIL seq_start k=%0d got=%b expected=%b", k, stage_start, exp_start);
            end
            checks++;
            if (stage_idx !== exp_idx) begin
                errors++;
                $display("FAIL seq_idx k=%0d got=%0d expected=%0d", k, stage_idx, exp_idx);
            end
            checks++;
            if (busy !== (k < 19)) begin
                errors++;
                $display("FAIL seq_busy k=%0d got=%b expected=%b", k, busy, k < 19);
            end
            if (k == 19) begin
                checks++;
                if (frame_count !== FW'(exp_fc + 1)) begin
                    errors++;
                    $display("FAIL seq_fc got=%0d expected=%0d", frame_count, exp_fc + 1);
                end
                checks++;
                if (skipped_frames !== 8'(exp_skip + 1)) begin
                    errors++;
                    $display("FAIL seq_return_skip got=%0d expected=%0d",
                             skipped_frames, exp_skip + 1);
                end
            end
            stage_done = (k == 6) ? 3'b001 : (k == 12) ? 3'b010 :
                         (k == 18) ? 3'b100 : 3'b000;
            vs = (k == 18);
            step();
        end
        stage_done = '0;
        exp_fc++;
        exp_skip++;
        checks++;
        if ({busy, stage_start} !== 4'b0000) begin
            errors++;
            $display("FAIL seq_no_restart got busy=%b start=%b expected 0/000",
                     busy, stage_start);
        end
        step();
    endtask

    // Stage 1 never answers: start1 at k=4, forced advance to start2 at k=13.
    task automatic test_timeout();
        logic [N-1:0] exp_start;
        vs = 1'b1;
        step();
        vs = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            exp_start = (k == 1) ? 3'b001 : (k == 4) ? 3'b010 :
                        (k == 13) ? 3'b100 : 3'b000;
            checks++;
            if (stage_start !== exp_start) begin
                errors++;
                $display("FAIL to_start k=%0d got=%b expected=%b", k, stage_start, exp_start);
            end
            checks++;
            if (timeout !== (k >= 13)) begin
                errors++;
                $display("FAIL to_flag k=%0d got=%b expected=%b", k, timeout, k >= 13);
            end
            if (k == 16) begin
                checks++;
                if ({busy, frame_count} !== {1'b0, FW'(exp_fc + 1)}) begin
                    errors++;
                    $display("FAIL to_end got busy=%b fc=%0d expected 0/%0d",
                             busy, frame_count, exp_fc + 1);
                end
            end
            stage_done = (k == 3) ? 3'b001 : (k == 15) ? 3'b100 : 3'b000;
            step();
        end
        stage_done = '0;
        exp_fc++;
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got=%b expected=0", timeout);
        end
    endtask

    task automatic test_overrun();
        vs = 1'b1;
        step();                      // t+1 START0
        vs = 1'b0;
        step();                      // t+2 WAIT0
        de = 1'b1;
        step();                      // t+3
        de = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got=%b expected=1", overrun);
        end
        step();                      // t+4: de rise + clear together
        de = 1'b1; clear_flags = 1'b1;
        step();                      // t+5
        de = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins got=%b expected=1", overrun);
        end
        step();                      // t+6 lone clear
        clear_flags = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got=%b expected=0", overrun);
        end
        finish_from_wait(0);
        exp_fc++;
        checks++;
        if ({busy, frame_count} !== {1'b0, FW'(exp_fc)}) begin
            errors++;
            $display("FAIL ovr_end got busy=%b fc=%0d expected 0/%0d",
                     busy, frame_count, exp_fc);
        end
        step();
    endtask

    task automatic test_stray();
        vs = 1'b1;
        step();                      // t+1 START0
        vs = 1'b0;
        stage_done = 3'b001;         // coincident with START: lost
        step();                      // t+2 WAIT0
        stage_done = 3'b100;         // stray, not the current stage
        step();                      // t+3
        stage_done = '0;
        checks++;
        if ({stage_start, stage_idx, busy} !== {3'b000, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL stray_hold got start=%b idx=%0d busy=%b expected 000/0/1",
                     stage_start, stage_idx, busy);
        end
        step();                      // t+4 still WAIT0
        stage_done = 3'b001;
        step();                      // t+5
        stage_done = '0;
        checks++;
        if (stage_start !== 3'b010) begin
            errors++;
            $display("FAIL stray_advance got=%b expected=010", stage_start);
        end
        step();
        finish_from_wait(1);
        exp_fc++;
        checks++;
        if (frame_count !== FW'(exp_fc)) begin
            errors++;
            $display("FAIL stray_fc got=%0d expected=%0d", frame_count, exp_fc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        vs = 1'b1;
        step();                      // START0
        vs = 1'b0;
        step();                      // WAIT0
        stage_done = 3'b001;
        step();                      // START1
        stage_done = '0;
        step();                      // WAIT1
        rst = 1'b1;
        step();
        checks++;
        if ({stage_start, stage_idx, busy, overrun, timeout, frame_count, skipped_frames} !== '0) begin
            errors++;
            $display("FAIL rst_mid got start=%b idx=%0d busy=%b fc=%0d skip=%0d expected all 0",
                     stage_start, stage_idx, busy, frame_count, skipped_frames);
        end
        rst = 1'b0;
        exp_fc = 0;
        exp_skip = 0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got busy=%b expected=0", busy);
        end
        vs = 1'b1;
        step();
        vs = 1'b0;
        checks++;
        if ({stage_start, stage_idx, busy} !== {3'b001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_restart got start=%b idx=%0d busy=%b expected 001/0/1",
                     stage_start, stage_idx, busy);
        end
        step();
        finish_from_wait(0);
        exp_fc++;
        checks++;
        if (frame_count !== FW'(exp_fc)) begin
            errors++;
            $display("FAIL rst_mid_fc got=%0d expected=%0d", frame_count, exp_fc);
        end
        step();
    endtask

    task automatic test_skip_saturate();
        vs = 1'b1;
        step();                      // t+1 START0
        vs = 1'b0;
        step();                      // t+2 WAIT0
        vs = 1'b1;
        step();                      // t+3
        vs = 1'b0;
        checks++;
        if (skipped_frames !== 8'(exp_skip + 1)) begin
            errors++;
            $display("FAIL skip_one got=%0d expected=%0d", skipped_frames, exp_skip + 1);
        end
        checks++;
        if ({stage_start, stage_idx} !== {3'b000, 2'd0}) begin
            errors++;
            $display("FAIL skip_no_restart got start=%b idx=%0d expected 000/0",
                     stage_start, stage_idx);
        end
        // Enough busy-time edges to exceed 255 even with idle restarts between.
        for (int i = 0; i < 400; i++) begin
            vs = 1'b1;
            step();
            vs = 1'b0;
            step();
        end
        checks++;
        if (skipped_frames !== 8'd255) begin
            errors++;
            $display("FAIL skip_saturate got=%0d expected=255", skipped_frames);
        end
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_sequence();
        test_timeout();
        test_overrun();
        test_stray();
        test_reset_mid();
        test_skip_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
